// File: rtl/wb_pkg.sv
// Shared write-back types and default widths for the register-file write arbiter.
package wb_pkg;

    localparam int WB_WIDTH = 32;
    localparam int WB_N     = 5;

    typedef struct packed {
        logic                en;
        logic [WB_N-1:0]     index;
        logic [WB_WIDTH-1:0] data;
    } wb_token_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry FIFO with count-based full/empty, used to buffer one write-back channel.
module wb_skid_fifo #(
    parameter int W = 37
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= !wr_ptr;
            if (do_pop)  rd_ptr <= !rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset: occupancy is tracked solely by count.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges ALU (A) and load (B) write-back channels into one registered register-file write token.
// Optional B anti-starvation guard enabled by defining WB_STARVE_GUARD_EN.
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int width        = WB_WIDTH,
    parameter int n            = WB_N,
    parameter int STARVE_LIMIT = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [n-1:0]     A_INDEX,
    input  logic [width-1:0] A_DATA,
    input  logic             A_VALID,
    output logic             A_CONSUMED,
    input  logic [n-1:0]     B_INDEX,
    input  logic [width-1:0] B_DATA,
    input  logic             B_VALID,
    output logic             B_CONSUMED,
    output logic             WRITE_EN_WRITE,
    output logic [n-1:0]     WRITE_INDEX_WRITE,
    output logic [width-1:0] WRITE_DATA_WRITE,
    output logic             WRITE_EN_WRITE_VALID,
    output logic             WRITE_INDEX_WRITE_VALID,
    output logic             WRITE_DATA_WRITE_VALID,
    input  logic             WRITE_EN_WRITE_CONSUMED,
    input  logic             WRITE_INDEX_WRITE_CONSUMED,
    input  logic             WRITE_DATA_WRITE_CONSUMED
);

    localparam int EW = n + width;

    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("STARVE_LIMIT must be at least 1");
    end

    logic [EW-1:0]    a_head, b_head;
    logic             a_full, a_empty, b_full, b_empty;
    logic             a_pop, b_pop;
    logic             grant_a, grant_b, force_b;
    logic             out_xfer;
    logic             nxt_en;
    logic [n-1:0]     nxt_index;
    logic [width-1:0] nxt_data;
    logic             out_en_p1;
    logic [n-1:0]     out_index_p1;
    logic [width-1:0] out_data_p1;

    assign A_CONSUMED = !a_full;
    assign B_CONSUMED = !b_full;
    assign out_xfer   = WRITE_EN_WRITE_CONSUMED && WRITE_INDEX_WRITE_CONSUMED
                        && WRITE_DATA_WRITE_CONSUMED;

    wb_skid_fifo #(.W(EW)) u_fifo_a (
        .CLK(CLK), .RST_N(RST_N),
        .push(A_VALID && A_CONSUMED), .push_data({A_INDEX, A_DATA}),
        .pop(a_pop), .head(a_head), .full(a_full), .empty(a_empty)
    );

    wb_skid_fifo #(.W(EW)) u_fifo_b (
        .CLK(CLK), .RST_N(RST_N),
        .push(B_VALID && B_CONSUMED), .push_data({B_INDEX, B_DATA}),
        .pop(b_pop), .head(b_head), .full(b_full), .empty(b_empty)
    );

`ifdef WB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;

    assign force_b = !b_empty && (starve_cnt >= CW'(STARVE_LIMIT));

    // Counts A grants that overtook a waiting B; any B grant or idle B restarts it.
    always_ff @(posedge CLK) begin
        if (!RST_N)                 starve_cnt <= '0;
        else if (b_empty)           starve_cnt <= '0;
        else if (out_xfer && grant_b) starve_cnt <= '0;
        else if (out_xfer && grant_a) starve_cnt <= starve_cnt + 1'b1;
    end
`else
    assign force_b = 1'b0;
`endif

    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        nxt_en    = 1'b0;
        nxt_index = '0;
        nxt_data  = '0;
        if (!a_empty && !force_b) begin
            grant_a = 1'b1;
            nxt_en  = 1'b1;
            {nxt_index, nxt_data} = a_head;
        end else if (!b_empty) begin
            grant_b = 1'b1;
            nxt_en  = 1'b1;
            {nxt_index, nxt_data} = b_head;
        end
    end

    assign a_pop = out_xfer && grant_a;
    assign b_pop = out_xfer && grant_b;

    // Output token stage: only advances when the consumer takes the current token.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            out_en_p1    <= 1'b0;
            out_index_p1 <= '0;
            out_data_p1  <= '0;
        end else if (out_xfer) begin
            out_en_p1    <= nxt_en;
            out_index_p1 <= nxt_index;
            out_data_p1  <= nxt_data;
        end
    end

    assign WRITE_EN_WRITE          = out_en_p1;
    assign WRITE_INDEX_WRITE       = out_index_p1;
    assign WRITE_DATA_WRITE        = out_data_p1;
    assign WRITE_EN_WRITE_VALID    = 1'b1;
    assign WRITE_INDEX_WRITE_VALID = 1'b1;
    assign WRITE_DATA_WRITE_VALID  = 1'b1;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter (both with and without WB_STARVE_GUARD_EN).
module tb_wb_write_arbiter;
    import wb_pkg::*;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic [WB_N-1:0] A_INDEX, B_INDEX;
    logic [31:0]     A_DATA, B_DATA;
    logic            A_VALID, B_VALID, A_CONSUMED, B_CONSUMED;
    logic            WRITE_EN_WRITE;
    logic [WB_N-1:0] WRITE_INDEX_WRITE;
    logic [31:0]     WRITE_DATA_WRITE;
    logic            WRITE_EN_WRITE_VALID, WRITE_INDEX_WRITE_VALID, WRITE_DATA_WRITE_VALID;
    logic            cons;

    int n_cmp = 0;
    int n_bad = 0;
    logic guard;
    wb_token_t out_tok;

    always #5 CLK = ~CLK;

    wb_write_arbiter #(.width(32), .n(WB_N), .STARVE_LIMIT(3)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .A_INDEX(A_INDEX), .A_DATA(A_DATA), .A_VALID(A_VALID), .A_CONSUMED(A_CONSUMED),
        .B_INDEX(B_INDEX), .B_DATA(B_DATA), .B_VALID(B_VALID), .B_CONSUMED(B_CONSUMED),
        .WRITE_EN_WRITE(WRITE_EN_WRITE), .WRITE_INDEX_WRITE(WRITE_INDEX_WRITE),
        .WRITE_DATA_WRITE(WRITE_DATA_WRITE),
        .WRITE_EN_WRITE_VALID(WRITE_EN_WRITE_VALID),
        .WRITE_INDEX_WRITE_VALID(WRITE_INDEX_WRITE_VALID),
        .WRITE_DATA_WRITE_VALID(WRITE_DATA_WRITE_VALID),
        .WRITE_EN_WRITE_CONSUMED(cons), .WRITE_INDEX_WRITE_CONSUMED(cons),
        .WRITE_DATA_WRITE_CONSUMED(cons)
    );

    assign out_tok = {WRITE_EN_WRITE, WRITE_INDEX_WRITE, WRITE_DATA_WRITE};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic en, input logic [WB_N-1:0] idx,
                                       input logic [31:0] data);
        wb_token_t t;
        t.en    = en;
        t.index = idx;
        t.data  = data;
        return 64'(t);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_tok(input string tag, input logic [63:0] exp);
        check_val(tag, 64'(out_tok), exp);
    endtask

    initial begin
`ifdef WB_STARVE_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        RST_N = 1'b0; cons = 1'b1;
        A_VALID = 1'b0; A_INDEX = '0; A_DATA = '0;
        B_VALID = 1'b0; B_INDEX = '0; B_DATA = '0;
        step(); step();
        check_tok("reset_token", mk(0, 0, 0));
        check_val("reset_a_cons", 64'(A_CONSUMED), 64'd1);
        check_val("reset_b_cons", 64'(B_CONSUMED), 64'd1);
        RST_N = 1'b1;
        step();
        check_val("post_reset_valids",
                  64'({WRITE_EN_WRITE_VALID, WRITE_INDEX_WRITE_VALID, WRITE_DATA_WRITE_VALID}),
                  64'd7);

        // Single A write: one cycle through the FIFO, then a bubble
        A_VALID = 1'b1; A_INDEX = 5'd3; A_DATA = 32'hDEAD;
        step();
        A_VALID = 1'b0;
        check_tok("lat_before", mk(0, 0, 0));
        step();
        check_tok("lat_token", mk(1, 3, 32'hDEAD));
        step();
        check_tok("lat_bubble", mk(0, 0, 0));

        // Same-index simultaneous writes: A first, then B, never merged
        A_VALID = 1'b1; A_INDEX = 5'd5; A_DATA = 32'h1;
        B_VALID = 1'b1; B_INDEX = 5'd5; B_DATA = 32'h2;
        step();
        A_VALID = 1'b0; B_VALID = 1'b0;
        step();
        check_tok("same_idx_a", mk(1, 5, 32'h1));
        step();
        check_tok("same_idx_b", mk(1, 5, 32'h2));
        step();
        check_tok("same_idx_bubble", mk(0, 0, 0));

        // Index 0 through channel B
        B_VALID = 1'b1; B_INDEX = 5'd0; B_DATA = 32'hCAFE;
        step();
        B_VALID = 1'b0;
        step();
        check_tok("idx0_b", mk(1, 0, 32'hCAFE));

        // Backpressure: consumer stalls 4 cycles while A offers 3 tokens
        cons = 1'b0;
        A_VALID = 1'b1; A_INDEX = 5'd7; A_DATA = 32'h11;
        step();
        check_val("bp_a_cons_1", 64'(A_CONSUMED), 64'd1);
        check_tok("bp_frozen_1", mk(1, 0, 32'hCAFE));
        A_DATA = 32'h12;
        step();
        check_val("bp_a_cons_2", 64'(A_CONSUMED), 64'd0);
        A_DATA = 32'h13;
        step();
        check_val("bp_a_cons_3", 64'(A_CONSUMED), 64'd0);
        step();
        check_tok("bp_frozen_4", mk(1, 0, 32'hCAFE));
        cons = 1'b1;
        step();
        check_tok("bp_out_1", mk(1, 7, 32'h11));
        check_val("bp_a_cons_rel", 64'(A_CONSUMED), 64'd1);
        step();
        A_VALID = 1'b0;
        check_tok("bp_out_2", mk(1, 7, 32'h12));
        step();
        check_tok("bp_out_3", mk(1, 7, 32'h13));
        step();
        check_tok("bp_bubble", mk(0, 0, 0));

        // Both channels continuously valid: grant pattern depends on the starvation guard
        A_VALID = 1'b1; A_INDEX = 5'd1; A_DATA = 32'hA;
        B_VALID = 1'b1; B_INDEX = 5'd2; B_DATA = 32'hB;
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            if (guard && (k % 4 == 3)) check_tok($sformatf("grant_%0d", k), mk(1, 2, 32'hB));
            else                        check_tok($sformatf("grant_%0d", k), mk(1, 1, 32'hA));
        end

        // Fill both FIFOs, then reset: nothing buffered may ever emerge
        cons = 1'b0;
        step(); step(); step();
        check_val("full_a_cons", 64'(A_CONSUMED), 64'd0);
        check_val("full_b_cons", 64'(B_CONSUMED), 64'd0);
        RST_N = 1'b0; A_VALID = 1'b0; B_VALID = 1'b0; cons = 1'b1;
        step();
        RST_N = 1'b1;
        check_tok("rst_mid_token", mk(0, 0, 0));
        check_val("rst_mid_a_cons", 64'(A_CONSUMED), 64'd1);
        check_val("rst_mid_b_cons", 64'(B_CONSUMED), 64'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            check_tok($sformatf("rst_no_stale_%0d", k), mk(0, 0, 0));
        end

        // Idle: a bubble every cycle with all VALIDs high
        for (int k = 0; k < 10; k++) begin
            step();
            check_val($sformatf("idle_en_%0d", k), 64'(WRITE_EN_WRITE), 64'd0);
            check_val($sformatf("idle_valid_%0d", k),
                      64'({WRITE_EN_WRITE_VALID, WRITE_INDEX_WRITE_VALID, WRITE_DATA_WRITE_VALID}),
                      64'd7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
